// File: rtl/hd44780_rx.sv
`default_nettype none
// ============================================================================
// Module  : hd44780_rx
// Purpose : HD44780-style 8-bit LCD bus responder: DDRAM, address counter,
//           display shift/control state and a character read port.
// Rev     : 1.0  initial release
// ============================================================================
module hd44780_rx #(
  parameter int         BUSY_CYCLES = 37,
  parameter logic [7:0] SPACE_CHAR  = 8'h20
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic [7:0] LCD_DATA,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  output logic [7:0] lcd_dout,
  output logic       lcd_dout_oe,
  input  logic       rd_row,
  input  logic [3:0] rd_col,
  output logic [7:0] rd_char,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [6:0] cursor_addr,
  output logic       busy,
  output logic       cmd_err
);

  localparam int c_MEM_DEPTH = 80;

  typedef enum logic [2:0] {
    ST_INIT_CLR = 3'd0,
    ST_IDLE     = 3'd1,
    ST_EXEC     = 3'd2,
    ST_CLR      = 3'd3,
    ST_BUSY     = 3'd4
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt;
  logic       r_en_s1, r_en_s2, r_en_prev, r_rs_s1, r_rs_s2, r_rw_s1, r_rw_s2;
  logic [7:0] r_data_s1, r_data_s2;
  logic       r_op_rs, r_op_rw;
  logic [7:0] r_op_data;
  logic       r_disp, r_cursor, r_blink, r_id, r_s, r_n, r_cgram, r_cmd_err;
  logic [6:0] r_ac;
  logic [5:0] r_shift;
  logic [7:0] r_dout, r_rd_char;
  logic       r_oe;
  logic [7:0] r_mem [c_MEM_DEPTH];

  logic       w_strobe, w_op_req, w_drop, w_busy, w_is_clear, w_clr_done, w_busy_done;
  logic [6:0] w_ac_idx, w_ac_idx_safe, w_view_pos, w_view_mod40, w_view_idx, w_mem_addr;
  logic       w_ac_ok, w_addr_ok, w_mem_we;
  logic [7:0] w_mem_wdata;
  logic [6:0] w_new_addr;

  function automatic logic [6:0] f_ac_next(input logic [6:0] ac, input logic inc, input logic n);
    logic [6:0] v;
    if (n) begin
      if (inc) v = (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
      else     v = (ac == 7'h00) ? 7'h67 : (ac == 7'h40) ? 7'h27 : ac - 7'd1;
    end else begin
      if (inc) v = (ac >= 7'h4F) ? 7'h00 : ac + 7'd1;
      else     v = (ac == 7'h00) ? 7'h4F : ac - 7'd1;
    end
    return v;
  endfunction

  function automatic logic [5:0] f_shift_next(input logic [5:0] s, input logic inc);
    logic [5:0] v;
    if (inc) v = (s >= 6'd39) ? 6'd0 : s + 6'd1;
    else     v = (s == 6'd0) ? 6'd39 : s - 6'd1;
    return v;
  endfunction

  // Busy-flag/AC reads (RS=0, RW=1) are pure reads and never become operations.
  assign w_strobe    = r_en_prev & ~r_en_s2;
  assign w_op_req    = w_strobe & ~(r_rw_s2 & ~r_rs_s2);
  assign w_busy      = (r_state != ST_IDLE);
  assign w_drop      = w_op_req & w_busy;
  assign w_is_clear  = ~r_op_rs & (r_op_data == 8'h01);
  assign w_clr_done  = (r_cnt == 8'(c_MEM_DEPTH - 1));
  assign w_busy_done = (r_cnt == 8'(BUSY_CYCLES - 1));

  assign w_ac_idx      = r_n ? ({1'b0, r_ac[5:0]} + (r_ac[6] ? 7'd40 : 7'd0)) : r_ac;
  assign w_ac_ok       = (w_ac_idx < 7'(c_MEM_DEPTH));
  assign w_ac_idx_safe = w_ac_ok ? w_ac_idx : 7'd0;

  assign w_new_addr = r_op_data[6:0];
  assign w_addr_ok  = r_n ? ((w_new_addr < 7'h28) || (w_new_addr >= 7'h40 && w_new_addr < 7'h68))
                          : (w_new_addr < 7'h50);

  // Column plus shift never exceeds 54, so a single conditional subtract gives mod 40.
  assign w_view_pos   = {3'b000, rd_col} + {1'b0, r_shift};
  assign w_view_mod40 = (w_view_pos >= 7'd40) ? w_view_pos - 7'd40 : w_view_pos;
  assign w_view_idx   = r_n ? (rd_row ? w_view_mod40 + 7'd40 : w_view_mod40) : w_view_pos;

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = w_ac_idx_safe;
    w_mem_wdata = r_op_data;
    if (r_state == ST_INIT_CLR || r_state == ST_CLR) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_cnt[6:0];
      w_mem_wdata = SPACE_CHAR;
    end else if (r_state == ST_EXEC && r_op_rs && !r_op_rw && !r_cgram && w_ac_ok) begin
      w_mem_we = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT_CLR, ST_CLR: if (w_clr_done) w_state_nxt = ST_IDLE;
      ST_IDLE:             if (w_op_req) w_state_nxt = ST_EXEC;
      ST_EXEC:             w_state_nxt = w_is_clear ? ST_CLR : ST_BUSY;
      ST_BUSY:             if (w_busy_done) w_state_nxt = ST_IDLE;
      default:             w_state_nxt = ST_INIT_CLR;
    endcase
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      r_state <= ST_INIT_CLR;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? 8'd0 : r_cnt + 8'd1;
    end
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      {r_en_s1, r_en_s2, r_en_prev} <= 3'b000;
      {r_rs_s1, r_rs_s2, r_rw_s1, r_rw_s2} <= 4'b0000;
      r_data_s1 <= 8'd0;
      r_data_s2 <= 8'd0;
    end else begin
      r_en_s1   <= LCD_EN;
      r_en_s2   <= r_en_s1;
      r_en_prev <= r_en_s2;
      r_rs_s1   <= LCD_RS;
      r_rs_s2   <= r_rs_s1;
      r_rw_s1   <= LCD_RW;
      r_rw_s2   <= r_rw_s1;
      r_data_s1 <= LCD_DATA;
      r_data_s2 <= r_data_s1;
    end
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      r_disp    <= 1'b0;
      r_cursor  <= 1'b0;
      r_blink   <= 1'b0;
      r_id      <= 1'b1;
      r_s       <= 1'b0;
      r_n       <= 1'b1;
      r_ac      <= 7'd0;
      r_shift   <= 6'd0;
      r_cgram   <= 1'b0;
      r_cmd_err <= 1'b0;
      r_op_rs   <= 1'b0;
      r_op_rw   <= 1'b0;
      r_op_data <= 8'd0;
    end else begin
      r_cmd_err <= w_drop;
      if (r_state == ST_IDLE && w_op_req) begin
        r_op_rs   <= r_rs_s2;
        r_op_rw   <= r_rw_s2;
        r_op_data <= r_data_s2;
      end
      if (r_state == ST_EXEC) begin
        if (r_op_rs) begin
          if (r_cgram) begin
            r_cmd_err <= 1'b1;
          end else begin
            r_ac <= f_ac_next(r_ac, r_id, r_n);
            if (!r_op_rw && r_s) r_shift <= f_shift_next(r_shift, r_id);
          end
        end else begin
          casez (r_op_data)
            8'b1???????: begin
              r_cgram <= 1'b0;
              if (w_addr_ok) r_ac <= w_new_addr;
              else           r_cmd_err <= 1'b1;
            end
            8'b01??????: begin
              r_cgram   <= 1'b1;
              r_cmd_err <= 1'b1;
            end
            8'b001?????: begin
              if (r_op_data[4]) r_n <= r_op_data[3];
              else              r_cmd_err <= 1'b1;
            end
            8'b0001????: begin
              if (r_op_data[3]) r_shift <= f_shift_next(r_shift, ~r_op_data[2]);
              else              r_ac    <= f_ac_next(r_ac, r_op_data[2], r_n);
            end
            8'b00001???: {r_disp, r_cursor, r_blink} <= r_op_data[2:0];
            8'b000001??: {r_id, r_s} <= r_op_data[1:0];
            8'b0000001?: begin
              r_ac    <= 7'd0;
              r_shift <= 6'd0;
            end
            8'b00000001: begin
              r_ac    <= 7'd0;
              r_shift <= 6'd0;
              r_id    <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  // Row 1 has no storage behind it in one-line mode.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      r_dout    <= 8'd0;
      r_oe      <= 1'b0;
      r_rd_char <= SPACE_CHAR;
    end else begin
      r_oe      <= r_en_s2 & r_rw_s2;
      r_dout    <= r_rs_s2 ? (w_ac_ok ? r_mem[w_ac_idx_safe] : SPACE_CHAR) : {w_busy, r_ac};
      r_rd_char <= (!r_disp || (!r_n && rd_row)) ? SPACE_CHAR : r_mem[w_view_idx];
    end
  end

  assign lcd_dout    = r_dout;
  assign lcd_dout_oe = r_oe;
  assign rd_char     = r_rd_char;
  assign disp_on     = r_disp;
  assign cursor_on   = r_cursor;
  assign blink_on    = r_blink;
  assign cursor_addr = r_ac;
  assign busy        = w_busy;
  assign cmd_err     = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_hd44780_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_hd44780_rx
// Purpose : Directed self-checking bench for the hd44780_rx bus responder.
// Rev     : 1.0  initial release
// ============================================================================
module tb_hd44780_rx;

  logic       iclk = 1'b0;
  logic       irst = 1'b1;
  logic [7:0] LCD_DATA = 8'd0;
  logic       LCD_RS = 1'b0, LCD_RW = 1'b0, LCD_EN = 1'b0;
  logic       rd_row = 1'b0;
  logic [3:0] rd_col = 4'd0;
  logic [7:0] lcd_dout, rd_char;
  logic       lcd_dout_oe, disp_on, cursor_on, blink_on, busy, cmd_err;
  logic [6:0] cursor_addr;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_err_pulse = 0;
  int         err_base;
  logic [7:0] rdat;
  logic       roe;
  string      hello = "HELLO WORLD 1234";
  string      fill  = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789abcd";

  hd44780_rx dut (
    .iclk(iclk), .irst(irst), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN), .lcd_dout(lcd_dout), .lcd_dout_oe(lcd_dout_oe), .rd_row(rd_row),
    .rd_col(rd_col), .rd_char(rd_char), .disp_on(disp_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .cursor_addr(cursor_addr), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 iclk = ~iclk;

  always @(negedge iclk) if (cmd_err === 1'b1) n_err_pulse++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 400) begin
      @(posedge iclk); #1;
      k++;
    end
    check("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic bus_strobe(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge iclk);
    LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_EN = 1'b1;
    repeat (4) @(negedge iclk);
    LCD_EN = 1'b0;
    repeat (4) @(negedge iclk);
    LCD_RW = 1'b0;
  endtask

  task automatic lcd_cmd(input logic [7:0] d);
    bus_strobe(1'b0, 1'b0, d);
    wait_idle();
  endtask

  task automatic lcd_data(input logic [7:0] d);
    bus_strobe(1'b1, 1'b0, d);
    wait_idle();
  endtask

  task automatic lcd_read(input logic rs, output logic [7:0] d, output logic oe);
    @(negedge iclk);
    LCD_RS = rs; LCD_RW = 1'b1; LCD_EN = 1'b1;
    repeat (4) @(negedge iclk);
    d  = lcd_dout;
    oe = lcd_dout_oe;
    LCD_EN = 1'b0;
    repeat (4) @(negedge iclk);
    LCD_RW = 1'b0;
    if (rs) wait_idle();
  endtask

  task automatic read_char(input logic row, input logic [3:0] col, output logic [7:0] c);
    @(negedge iclk);
    rd_row = row; rd_col = col;
    @(negedge iclk);
    c = rd_char;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_disp"},   {31'd0, disp_on},     32'd0);
    check({pfx, "_cursor"}, {31'd0, cursor_on},   32'd0);
    check({pfx, "_blink"},  {31'd0, blink_on},    32'd0);
    check({pfx, "_ac"},     {25'd0, cursor_addr}, 32'd0);
    check({pfx, "_busy"},   {31'd0, busy},        32'd1);
    check({pfx, "_err"},    {31'd0, cmd_err},     32'd0);
    check({pfx, "_dout"},   {24'd0, lcd_dout},    32'd0);
    check({pfx, "_oe"},     {31'd0, lcd_dout_oe}, 32'd0);
  endtask

  task automatic release_and_count(input string tag);
    int k = 0;
    @(negedge iclk);
    irst = 1'b1;
    do begin
      @(posedge iclk); #1;
      k++;
    end while (busy === 1'b1 && k < 200);
    check(tag, k, 32'd80);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 irst = 1'b0;
    repeat (3) @(negedge iclk);
    check_reset_outputs("rst");
    release_and_count("init_busy_cycles");

    // Basic bring-up and a 16-character line.
    lcd_cmd(8'h38); lcd_cmd(8'h0C); lcd_cmd(8'h01); lcd_cmd(8'h80);
    for (int i = 0; i < 16; i++) lcd_data(hello[i]);
    check("hello_ac",     {25'd0, cursor_addr}, 32'h10);
    check("hello_disp",   {31'd0, disp_on},     32'd1);
    check("hello_cursor", {31'd0, cursor_on},   32'd0);
    for (int i = 0; i < 16; i++) begin
      read_char(1'b0, 4'(i), rdat);
      check($sformatf("hello_col%0d", i), {24'd0, rdat}, {24'd0, hello[i]});
    end
    lcd_read(1'b0, rdat, roe);
    check("busy_ac_read", {24'd0, rdat}, 32'h10);
    check("busy_ac_oe",   {31'd0, roe},  32'd1);

    // Line-boundary wraps.
    lcd_cmd(8'hA7); lcd_data("A"); lcd_data("B");
    check("wrap_ac_41", {25'd0, cursor_addr}, 32'h41);
    read_char(1'b1, 4'd0, rdat);
    check("wrap_B_row1", {24'd0, rdat}, 32'h42);
    lcd_cmd(8'hA7);
    lcd_read(1'b1, rdat, roe);
    check("data_read_A", {24'd0, rdat}, 32'h41);
    check("data_read_ac", {25'd0, cursor_addr}, 32'h40);
    lcd_cmd(8'hE7); lcd_data("Z");
    check("wrap_ac_67_00", {25'd0, cursor_addr}, 32'h00);

    // Display shift.
    lcd_cmd(8'h80);
    for (int i = 0; i < 40; i++) lcd_data(fill[i]);
    check("fill_ac", {25'd0, cursor_addr}, 32'h40);
    repeat (3) lcd_cmd(8'h18);
    read_char(1'b0, 4'd0, rdat);  check("shl3_col0",  {24'd0, rdat}, 32'h44);
    read_char(1'b0, 4'd15, rdat); check("shl3_col15", {24'd0, rdat}, 32'h53);
    repeat (4) lcd_cmd(8'h1C);
    read_char(1'b0, 4'd0, rdat);  check("shr_col0",   {24'd0, rdat}, 32'h64);
    read_char(1'b0, 4'd1, rdat);  check("shr_col1",   {24'd0, rdat}, 32'h41);

    // Write during clear is dropped; busy read is served.
    err_base = n_err_pulse;
    bus_strobe(1'b0, 1'b0, 8'h01);
    bus_strobe(1'b1, 1'b0, 8'h41);
    lcd_read(1'b0, rdat, roe);
    check("busy_read_clr", {24'd0, rdat}, 32'h80);
    wait_idle();
    check("drop_err_pulses", n_err_pulse - err_base, 32'd1);
    lcd_read(1'b0, rdat, roe);
    check("busy_read_idle", {24'd0, rdat}, 32'h00);
    read_char(1'b0, 4'd0, rdat);
    check("drop_no_write", {24'd0, rdat}, 32'h20);

    // Function set, bad addresses, CGRAM mode.
    err_base = n_err_pulse;
    lcd_cmd(8'hC0); lcd_data("Q");
    read_char(1'b1, 4'd0, rdat); check("row1_Q", {24'd0, rdat}, 32'h51);
    lcd_cmd(8'h30);
    read_char(1'b1, 4'd0, rdat); check("n0_row1_space", {24'd0, rdat}, 32'h20);
    check("n0_ac_kept", {25'd0, cursor_addr}, 32'h41);
    lcd_cmd(8'h38);
    read_char(1'b1, 4'd0, rdat); check("n1_row1_Q", {24'd0, rdat}, 32'h51);
    check("func_ok_no_err", n_err_pulse - err_base, 32'd0);
    lcd_cmd(8'h20);
    check("dl0_err", n_err_pulse - err_base, 32'd1);
    read_char(1'b1, 4'd0, rdat); check("dl0_ignored", {24'd0, rdat}, 32'h51);
    lcd_cmd(8'hA8);
    check("bad_addr_err", n_err_pulse - err_base, 32'd2);
    check("bad_addr_ac",  {25'd0, cursor_addr}, 32'h41);
    lcd_cmd(8'h40);
    check("cgram_err", n_err_pulse - err_base, 32'd3);
    lcd_data(8'h55);
    check("cgram_data_err", n_err_pulse - err_base, 32'd4);
    check("cgram_data_ac",  {25'd0, cursor_addr}, 32'h41);
    lcd_cmd(8'h80);
    check("ddram_addr_no_err", n_err_pulse - err_base, 32'd4);
    read_char(1'b0, 4'd0, rdat); check("cgram_no_ddram", {24'd0, rdat}, 32'h20);

    // Reset in the middle of a clear.
    lcd_data("X");
    lcd_cmd(8'h0F);
    check("dcb_cursor", {31'd0, cursor_on}, 32'd1);
    check("dcb_blink",  {31'd0, blink_on},  32'd1);
    bus_strobe(1'b0, 1'b0, 8'h01);
    repeat (36) @(negedge iclk);
    irst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge iclk);
    release_and_count("midrst_busy_cycles");
    lcd_cmd(8'h0C);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 16; c++) begin
        read_char(r[0], 4'(c), rdat);
        check($sformatf("post_rst_r%0dc%0d", r, c), {24'd0, rdat}, 32'h20);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
